window_slide: RTL and testbench
===============================

WINDOW_SLIDE -- requirements
Module: window_slide

Interface
REQ-001 Parameters SHALL be: IMAGE_ROW_LEN, default 10, image height in pixels; IMAGE_COL_LEN, default 20, image width in pixels; KERNEL_SIZE, default 3, window side K; STRIDE, default 1, window step S in rows and columns.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 new_image  input  1  start strobe; the pixel on x_in in the same cycle is pixel 0.
REQ-005 x_in  input  1  binary pixel stream, row-major, one pixel per accepted cycle.
REQ-006 slide  input  1  stall; when high, x_in is not consumed and all internal state and outputs hold, except that valid_ws and done are forced low.
REQ-007 y_out  output  K*K x 1 (unpacked array [K*K-1:0])  current window, registered.
REQ-008 valid_ws  output  1  one-cycle qualifier for y_out.
REQ-009 done  output  1  one-cycle end-of-image pulse.
REQ-010 busy  output  1  high while an image is being ingested.

Function
REQ-011 An accepted cycle SHALL be a rising edge with (busy or new_image) high and slide low; each accepted cycle SHALL consume exactly one pixel.
REQ-012 new_image high in an accepted cycle SHALL reset the pixel counter to 0 and consume x_in as pixel (row 0, col 0), including when busy is already high (restart; the prior image is abandoned without done).
REQ-013 The pixel index SHALL advance col 0..IMAGE_COL_LEN-1, then wrap to col 0 of the next row; the total is IMAGE_ROW_LEN*IMAGE_COL_LEN pixels.
REQ-014 Storage SHALL be a line buffer of (K-1) full rows plus K pixels (shift register or RAM), holding the last (K-1)*IMAGE_COL_LEN+K pixels.
REQ-015 When pixel (r,c) is accepted with r>=K-1, c>=K-1, (r-K+1) mod S==0 and (c-K+1) mod S==0, the block SHALL register a window and set valid_ws=1 for exactly the following cycle.
REQ-016 The window mapping SHALL be: with top-left (wr,wc)=(r-K+1,c-K+1), y_out[i*K+j] = pixel(wr+i, wc+j) for i,j in 0..K-1; y_out[0] is the top-left pixel.
REQ-017 Windows SHALL never straddle a row wrap; the window count per image SHALL be ((ROW-K)/S+1)*((COL-K)/S+1) using integer division.
REQ-018 y_out SHALL hold its last value when valid_ws is low.
REQ-019 busy SHALL rise at the edge accepting pixel 0, stay high through the edge before the last pixel, and fall at the edge accepting the last pixel.
REQ-020 done SHALL be registered at the edge accepting the last pixel and be high for exactly one cycle, coincident with the final valid_ws when a final window exists.
REQ-021 Pixels presented while busy=0 and new_image=0 SHALL be ignored.
REQ-022 Parameters SHALL satisfy K<=IMAGE_ROW_LEN, K<=IMAGE_COL_LEN and S>=1; counters SHALL be sized with $clog2 of the parameters.

Reset
REQ-023 While rst=1, all of the following SHALL hold: busy=0, done=0, valid_ws=0, all y_out bits 0, counters 0, and line buffer contents 0.
REQ-024 rst asserted mid-image SHALL abort the image; after release the block SHALL be idle until new_image.

Verification
REQ-025 10x20 image with even rows all 1 and odd rows all 0, K=3, S=1, streamed contiguously -> exactly 144 valid_ws pulses; window 0 = {1,1,1,0,0,0,1,1,1}; windows 18..35 = {0,0,0,1,1,1,0,0,0}; done pulses once, with the 144th valid_ws.
REQ-026 Same image with S=2 -> 36 windows; first window top-left (0,0), second (0,2); no windows with top-left in odd rows.
REQ-027 Pixel value = (r*20+c) mod 2 with K=3 -> window 0 = {0,1,0,0,1,0,0,1,0}; this check verifies index ordering.
REQ-028 Hold slide=1 for 5 cycles mid-row -> the output window sequence is identical to the unstalled run, delayed by 5 cycles; no valid_ws occurs during the stall.
REQ-029 Assert rst at pixel 100, then restart with new_image -> no done for the aborted image; the full 144-window sequence follows.
REQ-030 Assert new_image at pixel 150 while busy=1 -> restart; the following windows are computed only from new pixels, and the total is 144 windows with one done.

Source files
------------

// File: rtl/window_slide_if.sv
// Pixel-stream and window-output bundle for window_slide.
// Latency: none (wires only).
// Backpressure: the master raises slide to stall the slave. The slave then holds its state and consumes no pixel.
// Signals:
//   new_image - start strobe (master -> slave)
//   x_in      - binary pixel (master -> slave)
//   slide     - stall request (master -> slave)
//   y_out     - K*K window, where y_out[0] is the top-left pixel (slave -> master)
//   valid_ws  - one-cycle qualifier for y_out (slave -> master)
//   done      - end-of-image pulse (slave -> master)
//   busy      - image ingest in progress (slave -> master)
interface window_slide_if #(
  parameter int KERNEL_SIZE = 3
) ();
  logic new_image;
  logic x_in;
  logic slide;
  logic y_out [KERNEL_SIZE*KERNEL_SIZE-1:0];
  logic valid_ws;
  logic done;
  logic busy;

  modport master (
    output new_image, x_in, slide,
    input  y_out, valid_ws, done, busy
  );

  modport slave (
    input  new_image, x_in, slide,
    output y_out, valid_ws, done, busy
  );
endinterface

// File: rtl/window_slide.sv
// Sliding K x K window generator over a row-major binary pixel stream, with stride S.
// Latency: a window is registered on the edge that accepts its bottom-right pixel, and valid_ws is high in the following cycle.
// Backpressure: while slide=1 the block consumes no pixel and holds its state, and valid_ws and done are forced low.
// Ports:
//   clk, rst - single clock, with an asynchronous active-high reset
//   ws       - slave side of window_slide_if (pixel stream in, window/valid/done/busy out)
module window_slide #(
  parameter int IMAGE_ROW_LEN = 10,
  parameter int IMAGE_COL_LEN = 20,
  parameter int KERNEL_SIZE   = 3,
  parameter int STRIDE        = 1
) (
  input  logic clk,
  input  logic rst,
  window_slide_if.slave ws
);

  localparam int K      = KERNEL_SIZE;
  localparam int NWIN   = K * K;
  // (K-1) full rows plus K pixels: enough history to reach the top-left tap.
  localparam int LB_LEN = (K - 1) * IMAGE_COL_LEN + K;
  localparam int RW     = (IMAGE_ROW_LEN > 1) ? $clog2(IMAGE_ROW_LEN) : 1;
  localparam int CW     = (IMAGE_COL_LEN > 1) ? $clog2(IMAGE_COL_LEN) : 1;
  localparam int SW     = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_ROW_LEN - 1);
  localparam logic [RW-1:0] ROW_KM1  = RW'(K - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_COL_LEN - 1);
  localparam logic [CW-1:0] COL_KM1  = CW'(K - 1);
  localparam logic [SW-1:0] S_LAST   = SW'(STRIDE - 1);

  if (K > IMAGE_ROW_LEN || K > IMAGE_COL_LEN || STRIDE < 1 || K < 1) begin : g_bad_param
    $error("window_slide: illegal parameter combination");
  end

  // The row and column counters hold the position of the next pixel to accept.
  // The phase counters hold (pos-K+1) mod S for that position, which avoids a divider.
  logic [RW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic [SW-1:0]     rph_q, rph_d;
  logic [SW-1:0]     cph_q, cph_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              valid_q, valid_d;
  logic [LB_LEN-1:0] lb_q, lb_d;
  logic              y_q [NWIN-1:0];
  logic              y_d [NWIN-1:0];

  logic              accept;
  logic [RW-1:0]     cur_r;
  logic [CW-1:0]     cur_c;
  logic [SW-1:0]     cur_rph;
  logic [SW-1:0]     cur_cph;
  logic              last_col;
  logic              last_pix;
  logic              win_hit;
  logic [LB_LEN-1:0] lb_shift;
  logic              win [NWIN-1:0];

  assign accept = (busy_q | ws.new_image) & ~ws.slide;

  // A start strobe overrides the running position (restart without done).
  assign cur_r   = ws.new_image ? '0 : row_q;
  assign cur_c   = ws.new_image ? '0 : col_q;
  assign cur_rph = ws.new_image ? '0 : rph_q;
  assign cur_cph = ws.new_image ? '0 : cph_q;

  assign last_col = (cur_c == COL_LAST);
  assign last_pix = last_col && (cur_r == ROW_LAST);
  assign win_hit  = (cur_r >= ROW_KM1) && (cur_c >= COL_KM1) &&
                    (cur_rph == '0) && (cur_cph == '0);

  // The window is tapped from the buffer as it will look after the shift.
  // The pixel being accepted is therefore already the bottom-right tap.
  always_comb begin
    lb_shift    = '0;
    lb_shift[0] = ws.x_in;
    for (int n = 1; n < LB_LEN; n++) begin
      lb_shift[n] = lb_q[n-1];
    end
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        win[i*K+j] = lb_shift[(K-1-i)*IMAGE_COL_LEN + (K-1-j)];
      end
    end
  end

  always_comb begin
    row_d   = row_q;
    col_d   = col_q;
    rph_d   = rph_q;
    cph_d   = cph_q;
    busy_d  = busy_q;
    lb_d    = lb_q;
    done_d  = 1'b0;
    valid_d = 1'b0;
    for (int n = 0; n < NWIN; n++) begin
      y_d[n] = y_q[n];
    end

    if (accept) begin
      lb_d    = lb_shift;
      busy_d  = ~last_pix;
      done_d  = last_pix;
      valid_d = win_hit;
      if (win_hit) begin
        for (int n = 0; n < NWIN; n++) begin
          y_d[n] = win[n];
        end
      end

      // Column phase restarts at 0 until the next column reaches K-1.
      if (last_col || (cur_c < COL_KM1)) begin
        cph_d = '0;
      end else begin
        cph_d = (cur_cph == S_LAST) ? '0 : cur_cph + 1'b1;
      end

      if (last_col) begin
        col_d = '0;
        row_d = last_pix ? '0 : cur_r + 1'b1;
        if (cur_r < ROW_KM1) begin
          rph_d = '0;
        end else begin
          rph_d = (cur_rph == S_LAST) ? '0 : cur_rph + 1'b1;
        end
      end else begin
        col_d = cur_c + 1'b1;
        row_d = cur_r;
        rph_d = cur_rph;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q   <= '0;
      col_q   <= '0;
      rph_q   <= '0;
      cph_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      lb_q    <= '0;
      for (int n = 0; n < NWIN; n++) begin
        y_q[n] <= 1'b0;
      end
    end else begin
      row_q   <= row_d;
      col_q   <= col_d;
      rph_q   <= rph_d;
      cph_q   <= cph_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      lb_q    <= lb_d;
      for (int n = 0; n < NWIN; n++) begin
        y_q[n] <= y_d[n];
      end
    end
  end

  assign ws.y_out    = y_q;
  assign ws.valid_ws = valid_q;
  assign ws.done     = done_q;
  assign ws.busy     = busy_q;

endmodule

// File: tb/tb_window_slide.sv
module tb_window_slide;

  logic clk;
  logic rst;

  window_slide_if #(.KERNEL_SIZE(3)) ifa ();
  window_slide_if #(.KERNEL_SIZE(3)) ifb ();

  // dut_a runs with stride 1 and dut_b with stride 2; both see the same pixel stream.
  window_slide #(.IMAGE_ROW_LEN(10), .IMAGE_COL_LEN(20), .KERNEL_SIZE(3), .STRIDE(1))
    dut_a (.clk(clk), .rst(rst), .ws(ifa));
  window_slide #(.IMAGE_ROW_LEN(10), .IMAGE_COL_LEN(20), .KERNEL_SIZE(3), .STRIDE(2))
    dut_b (.clk(clk), .rst(rst), .ws(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] w;
    int         t;
  } exp_t;

  exp_t       exp_a[$];
  exp_t       exp_b[$];
  logic [8:0] obs_a[$];
  int         obs_tb[$];
  int         checks;
  int         errors;
  int         win_a, win_b, done_a, done_b;
  int         cyc;
  logic [8:0] last_a;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Test images: mode 0 has even rows all 1 and odd rows all 0; mode 1 has pixel value (r*20+c) mod 2.
  function automatic logic pix(input int mode, input int r, input int c);
    if (mode == 0) return (r % 2) == 0;
    return ((r * 20 + c) % 2) == 1;
  endfunction

  // Builds the expected window list for one image.
  // A window is expected at step p+1 after image start, plus the stall length if it falls after the stall.
  task automatic build(input int mode, input int stall_at, input int stall_len);
    exp_t e;
    exp_a.delete(); exp_b.delete(); obs_a.delete(); obs_tb.delete();
    win_a = 0; win_b = 0; done_a = 0; done_b = 0; cyc = 0;
    for (int p = 0; p < 200; p++) begin
      int r, c;
      r = p / 20; c = p % 20;
      if (r >= 2 && c >= 2) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            e.w[i*3+j] = pix(mode, r - 2 + i, c - 2 + j);
        e.t = p + 1 + ((stall_at >= 0 && p >= stall_at) ? stall_len : 0);
        exp_a.push_back(e);
        if (((r - 2) % 2 == 0) && ((c - 2) % 2 == 0)) exp_b.push_back(e);
      end
    end
  endtask

  task automatic drive(input logic ni, input logic x, input logic sl);
    ifa.new_image = ni; ifa.x_in = x; ifa.slide = sl;
    ifb.new_image = ni; ifb.x_in = x; ifb.slide = sl;
  endtask

  // One clock: drive the inputs, then sample just after the edge and score the windows and done pulses.
  task automatic step(input logic ni, input logic x, input logic sl);
    logic [8:0] ya, yb;
    exp_t e;
    drive(ni, x, sl);
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 9; i++) begin
      ya[i] = ifa.y_out[i];
      yb[i] = ifb.y_out[i];
    end
    if (ifa.valid_ws === 1'b1) begin
      win_a++;
      obs_a.push_back(ya);
      chk("a_window_expected", {31'b0, exp_a.size() > 0}, 1);
      if (exp_a.size() > 0) begin
        e = exp_a.pop_front();
        chk("a_window_data", {23'b0, ya}, {23'b0, e.w});
        chk("a_window_time", cyc, e.t);
      end
      last_a = ya;
    end else begin
      chk("a_y_hold", {23'b0, ya}, {23'b0, last_a});
    end
    if (ifa.done === 1'b1) begin
      done_a++;
      chk("a_done_with_last_window", {31'b0, ifa.valid_ws & (exp_a.size() == 0)}, 1);
      chk("a_done_window_count", win_a, 144);
    end
    if (ifb.valid_ws === 1'b1) begin
      win_b++;
      obs_tb.push_back(cyc);
      chk("b_window_expected", {31'b0, exp_b.size() > 0}, 1);
      if (exp_b.size() > 0) begin
        e = exp_b.pop_front();
        chk("b_window_data", {23'b0, yb}, {23'b0, e.w});
        chk("b_window_time", cyc, e.t);
      end
    end
    if (ifb.done === 1'b1) begin
      done_b++;
      chk("b_done_all_windows", {31'b0, exp_b.size() == 0}, 1);
    end
  endtask

  // Streams npix pixels of an image.
  // If stall_at >= 0, slide is held for stall_len cycles just before pixel stall_at is presented.
  task automatic feed(input int mode, input int npix, input int stall_at, input int stall_len);
    build(mode, stall_at, stall_len);
    for (int p = 0; p < npix; p++) begin
      logic px;
      px = pix(mode, p / 20, p % 20);
      if (p == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          step(1'b0, ~px, 1'b1);
          chk("stall_no_valid", {31'b0, ifa.valid_ws}, 0);
          chk("stall_no_done", {31'b0, ifa.done}, 0);
          chk("stall_busy_held", {31'b0, ifa.busy}, 1);
        end
      end
      step(p == 0, px, 1'b0);
      chk("busy", {31'b0, ifa.busy}, {31'b0, p != 199});
    end
  endtask

  task automatic check_full_image(input string tag);
    chk({tag, "_a_windows"}, win_a, 144);
    chk({tag, "_a_done"}, done_a, 1);
    chk({tag, "_b_windows"}, win_b, 36);
    chk({tag, "_b_done"}, done_b, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    logic [8:0] ya;
    for (int i = 0; i < 9; i++) ya[i] = ifa.y_out[i];
    chk({tag, "_busy"}, {31'b0, ifa.busy}, 0);
    chk({tag, "_done"}, {31'b0, ifa.done}, 0);
    chk({tag, "_valid"}, {31'b0, ifa.valid_ws}, 0);
    chk({tag, "_y"}, {23'b0, ya}, 0);
    chk({tag, "_b_busy"}, {31'b0, ifb.busy}, 0);
  endtask

  initial begin
    checks = 0; errors = 0; last_a = '0;
    win_a = 0; win_b = 0; done_a = 0; done_b = 0; cyc = 0;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0);

    // Reset state.
    #3;
    check_reset_outputs("reset");
    @(posedge clk); @(posedge clk);
    #2 rst = 1'b0;

    // Idle pixels without new_image are ignored.
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 1'b0);
      chk("idle_busy", {31'b0, ifa.busy}, 0);
      chk("idle_valid", {31'b0, ifa.valid_ws}, 0);
      chk("idle_b_valid", {31'b0, ifb.valid_ws}, 0);
    end

    // Striped image with stride 1 and stride 2.
    feed(0, 200, -1, 0);
    check_full_image("stripes");
    chk("stripes_win0", {23'b0, obs_a[0]}, 32'h1c7);
    for (int k = 18; k <= 35; k++) chk("stripes_win_row1", {23'b0, obs_a[k]}, 32'h038);
    chk("stride2_first_time", obs_tb[0], 43);
    chk("stride2_second_time", obs_tb[1], 45);
    step(1'b0, 1'b0, 1'b0);
    chk("post_image_busy", {31'b0, ifa.busy}, 0);
    chk("post_image_valid", {31'b0, ifa.valid_ws}, 0);

    // Index-ordering image.
    feed(1, 200, -1, 0);
    check_full_image("parity");
    chk("parity_win0", {23'b0, obs_a[0]}, 32'h092);
    step(1'b0, 1'b0, 1'b0);

    // A 5-cycle stall mid-row delays every later window by 5 cycles.
    feed(0, 200, 55, 5);
    check_full_image("stall");
    step(1'b0, 1'b0, 1'b0);

    // Reset after 100 pixels aborts the image; the block then stays idle until new_image.
    feed(0, 100, -1, 0);
    chk("abort_no_done", done_a, 0);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("abort_reset");
    @(posedge clk);
    #2 rst = 1'b0;
    last_a = '0;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 1'b0);
      chk("abort_idle_busy", {31'b0, ifa.busy}, 0);
      chk("abort_idle_valid", {31'b0, ifa.valid_ws}, 0);
    end
    feed(0, 200, -1, 0);
    check_full_image("after_abort");
    step(1'b0, 1'b0, 1'b0);

    // A new_image at pixel 150 while busy restarts the stream without a done for the abandoned image.
    feed(1, 150, -1, 0);
    chk("restart_no_done", done_a, 0);
    chk("restart_busy", {31'b0, ifa.busy}, 1);
    feed(0, 200, -1, 0);
    check_full_image("restart");
    step(1'b0, 1'b0, 1'b0);
    chk("final_busy", {31'b0, ifa.busy}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
